data_bus_mux_rr: RTL and testbench

Registered, parametrised data-bus multiplexer that drives the core's internal data bus from one of `NSRC` sources of `WIDTH` bits. It supports two modes: a directed mode (an explicit select chooses the source) and a round-robin mode (requesting sources are granted in rotation). It adds a valid/ready output handshake with stall hold and per-source grant strobes. It sits between the W register, ALU, register file, status and any added sources, and the bus consumers.

---
 rtl/data_bus_pkg.sv | 26 ++
 rtl/data_bus_mux_rr_pick.sv | 32 +++
 rtl/data_bus_mux_rr.sv | 138 +++++++++++++
 tb/tb_data_bus_mux_rr.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared definitions for the core data-bus multiplexer: mode encodings,
// legacy source indices and the select-width helper.
package data_bus_pkg;

    localparam logic MODE_DIRECTED = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    localparam int unsigned SRC_W       = 0;
    localparam int unsigned SRC_ALU     = 1;
    localparam int unsigned SRC_REGFILE = 2;
    localparam int unsigned SRC_STATUS  = 3;

    // Ceiling log2, never below 1 so a select field always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_bus_mux_rr_pick.sv
// Rotating-priority picker: searches req starting one past ptr, wrapping,
// and reports the first requester as one-hot, as an index and via an any flag.
module rr_pick
    import data_bus_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SEL_W = clog2(NSRC)
) (
    input  logic [NSRC-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [NSRC-1:0]  win_c,
    output logic [SEL_W-1:0] idx_c,
    output logic             any_c
);

    always_comb begin
        int unsigned cand;
        win_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = 0;
        for (int unsigned k = 1; k <= NSRC; k++) begin
            cand = (32'(ptr) + k) % NSRC;
            if (!any_c && req[cand]) begin
                any_c       = 1'b1;
                win_c[cand] = 1'b1;
                idx_c       = SEL_W'(cand);
            end
        end
    end

endmodule

// File: rtl/data_bus_mux_rr.sv
// Registered data-bus multiplexer with directed and round-robin source
// selection, a valid/ready output handshake and combinational grant strobes.
module data_bus_mux_rr
    import data_bus_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NSRC  = 4,
    parameter int unsigned SEL_W = clog2(NSRC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic [NSRC-1:0]       src_req,
    output logic [NSRC-1:0]       src_gnt,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_src,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [WIDTH-1:0] w_src [NSRC];
    logic             w_load;
    logic             w_sel_ok;
    logic [WIDTH-1:0] w_dir_data;
    logic [NSRC-1:0]  w_dir_gnt;
    logic [NSRC-1:0]  w_rr_win;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_rr_any;
    logic [WIDTH-1:0] w_rr_data;
    logic [NSRC-1:0]  w_gnt;
    logic [WIDTH-1:0] w_nxt_data;
    logic [SEL_W-1:0] w_nxt_src;
    logic             w_nxt_valid;
    logic [SEL_W-1:0] w_nxt_ptr;

    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_src;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_ptr;

    always_comb begin
        for (int unsigned i = 0; i < NSRC; i++) begin
            w_src[i] = src_data[i*WIDTH +: WIDTH];
        end
    end

    // Directed decode; select codes at or above NSRC match nothing.
    always_comb begin
        w_sel_ok   = 1'b0;
        w_dir_data = '0;
        w_dir_gnt  = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (SEL_W'(i) == sel) begin
                w_sel_ok     = 1'b1;
                w_dir_data   = w_src[i];
                w_dir_gnt[i] = 1'b1;
            end
        end
    end

    rr_pick #(
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_rr_pick (
        .req   (src_req),
        .ptr   (r_ptr),
        .win_c (w_rr_win),
        .idx_c (w_rr_idx),
        .any_c (w_rr_any)
    );

    always_comb begin
        w_rr_data = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (w_rr_win[i]) begin
                w_rr_data = w_rr_data | w_src[i];
            end
        end
    end

    assign w_load = !r_out_valid || out_ready;

    // Next-state and grant selection; a stalled word holds everything.
    always_comb begin
        w_gnt       = '0;
        w_nxt_data  = r_out_data;
        w_nxt_src   = r_out_src;
        w_nxt_valid = r_out_valid;
        w_nxt_ptr   = r_ptr;
        if (w_load) begin
            if (mode == MODE_DIRECTED) begin
                if (w_sel_ok) begin
                    w_gnt       = w_dir_gnt;
                    w_nxt_data  = w_dir_data;
                    w_nxt_src   = sel;
                    w_nxt_valid = 1'b1;
                end else begin
                    w_nxt_data  = '0;
                    w_nxt_src   = '0;
                    w_nxt_valid = 1'b0;
                end
            end else begin
                if (w_rr_any) begin
                    w_gnt       = w_rr_win;
                    w_nxt_data  = w_rr_data;
                    w_nxt_src   = w_rr_idx;
                    w_nxt_valid = 1'b1;
                    w_nxt_ptr   = w_rr_idx;
                end else begin
                    w_nxt_valid = 1'b0;
                end
            end
        end
    end

    // ptr resets to the last index so source 0 is searched first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SEL_W'(NSRC - 1);
        end else begin
            r_out_data  <= w_nxt_data;
            r_out_src   <= w_nxt_src;
            r_out_valid <= w_nxt_valid;
            r_ptr       <= w_nxt_ptr;
        end
    end

    assign src_gnt   = rst ? '0 : w_gnt;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_data_bus_mux_rr.sv
// Directed-vector bench for data_bus_mux_rr: a 4-source instance for the main
// table and reset sequences, and a 3-source instance for out-of-range select.
module tb_data_bus_mux_rr;
    import data_bus_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned N   = 4;
    localparam int unsigned SW  = 2;
    localparam int unsigned N3  = 3;
    localparam int unsigned SW3 = 2;
    localparam int unsigned NV  = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [N*W-1:0]  src_data;
    logic [N-1:0]    src_req;
    logic [N-1:0]    src_gnt;
    logic [W-1:0]    out_data;
    logic [SW-1:0]   out_src;
    logic            out_valid;
    logic            out_ready;

    logic            mode3;
    logic [SW3-1:0]  sel3;
    logic [N3*W-1:0] src_data3;
    logic [N3-1:0]   src_req3;
    logic [N3-1:0]   src_gnt3;
    logic [W-1:0]    out_data3;
    logic [SW3-1:0]  out_src3;
    logic            out_valid3;
    logic            out_ready3;

    data_bus_mux_rr #(.WIDTH(W), .NSRC(N), .SEL_W(SW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .src_data(src_data),
        .src_req(src_req), .src_gnt(src_gnt), .out_data(out_data),
        .out_src(out_src), .out_valid(out_valid), .out_ready(out_ready)
    );

    data_bus_mux_rr #(.WIDTH(W), .NSRC(N3), .SEL_W(SW3)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .src_data(src_data3),
        .src_req(src_req3), .src_gnt(src_gnt3), .out_data(out_data3),
        .out_src(out_src3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    typedef struct {
        logic           mode;
        logic [SW-1:0]  sel;
        logic [N-1:0]   req;
        logic [N*W-1:0] data;
        logic           ready;
        logic [N-1:0]   e_gnt;
        logic [W-1:0]   e_data;
        logic [SW-1:0]  e_src;
        logic           e_valid;
    } vec_t;

    vec_t vecs [NV];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic m, input logic [SW-1:0] s,
                                input logic [N-1:0] r, input logic [N*W-1:0] d,
                                input logic rdy, input logic [N-1:0] eg,
                                input logic [W-1:0] ed, input logic [SW-1:0] es,
                                input logic ev);
        vec_t v;
        v.mode = m; v.sel = s; v.req = r; v.data = d; v.ready = rdy;
        v.e_gnt = eg; v.e_data = ed; v.e_src = es; v.e_valid = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [N*W-1:0] d;
        int unsigned    e;
        d = 32'h44A52211;

        // sources: 0=11 1=22 2=A5 3=44; ptr starts at 3 after reset
        vecs[0]  = mk(1'b0, 2'd2, 4'b0000, d, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1);
        vecs[1]  = mk(1'b0, 2'd0, 4'b1111, d, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
        vecs[2]  = mk(1'b1, 2'd0, 4'b1111, d, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
        vecs[3]  = mk(1'b1, 2'd0, 4'b1111, d, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[4]  = mk(1'b1, 2'd0, 4'b1111, d, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1);
        vecs[5]  = mk(1'b1, 2'd0, 4'b1111, d, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[6]  = mk(1'b1, 2'd0, 4'b1111, d, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);
        vecs[7]  = mk(1'b1, 2'd0, 4'b1010, d, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[8]  = mk(1'b1, 2'd0, 4'b1010, d, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[9]  = mk(1'b1, 2'd0, 4'b1010, d, 1'b1, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[10] = mk(1'b1, 2'd0, 4'b1010, d, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[11] = mk(1'b1, 2'd0, 4'b0000, d, 1'b1, 4'b0000, 8'h44, 2'd3, 1'b0);
        vecs[12] = mk(1'b1, 2'd0, 4'b0010, d, 1'b0, 4'b0010, 8'h22, 2'd1, 1'b1);
        vecs[13] = mk(1'b1, 2'd0, 4'b1111, d, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        vecs[14] = mk(1'b0, 2'd3, 4'b0000, d, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        vecs[15] = mk(1'b1, 2'd0, 4'b0100, 32'hFFFFFFFF, 1'b0, 4'b0000, 8'h22, 2'd1, 1'b1);
        vecs[16] = mk(1'b1, 2'd0, 4'b0110, d, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1);
        vecs[17] = mk(1'b0, 2'd3, 4'b0000, d, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[18] = mk(1'b1, 2'd0, 4'b1011, d, 1'b1, 4'b1000, 8'h44, 2'd3, 1'b1);
        vecs[19] = mk(1'b0, 2'd2, 4'b0000, 32'h44C32211, 1'b1, 4'b0100, 8'hC3, 2'd2, 1'b1);
        vecs[20] = mk(1'b0, 2'd0, 4'b0000, d, 1'b0, 4'b0000, 8'hC3, 2'd2, 1'b1);
        vecs[21] = mk(1'b0, 2'd0, 4'b0000, d, 1'b1, 4'b0001, 8'h11, 2'd0, 1'b1);

        rst = 1'b1;
        mode = MODE_DIRECTED; sel = '0; src_data = d; src_req = '0; out_ready = 1'b1;
        mode3 = MODE_DIRECTED; sel3 = '0; src_data3 = 24'h332211; src_req3 = '0; out_ready3 = 1'b1;
        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_data",  32'(out_data),  32'd0);
        chk("reset_src",   32'(out_src),   32'd0);
        chk("reset_gnt",   32'(src_gnt),   32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            mode = vecs[i].mode; sel = vecs[i].sel; src_req = vecs[i].req;
            src_data = vecs[i].data; out_ready = vecs[i].ready;
            @(negedge clk);
            chk($sformatf("v%0d_gnt", i), 32'(src_gnt), 32'(vecs[i].e_gnt));
            @(posedge clk); #1;
            chk($sformatf("v%0d_data", i),  32'(out_data),  32'(vecs[i].e_data));
            chk($sformatf("v%0d_src", i),   32'(out_src),   32'(vecs[i].e_src));
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
        end

        // Asynchronous reset mid-stream, then source 0 must win first.
        mode = MODE_RR; src_req = 4'b0010; out_ready = 1'b1; src_data = d;
        @(negedge clk);
        chk("pre_rst_gnt", 32'(src_gnt), 32'b0010);
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        src_req = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data",  32'(out_data),  32'd0);
        chk("mid_rst_src",   32'(out_src),   32'd0);
        chk("mid_rst_gnt",   32'(src_gnt),   32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("post_rst_gnt", 32'(src_gnt), 32'b0001);
        @(posedge clk); #1;
        chk("post_rst_src",  32'(out_src),  32'd0);
        chk("post_rst_data", 32'(out_data), 32'h11);

        // Three-source instance: valid word, then out-of-range select.
        sel3 = 2'd1;
        @(negedge clk);
        chk("n3_sel1_gnt", 32'(src_gnt3), 32'b010);
        @(posedge clk); #1;
        chk("n3_sel1_data",  32'(out_data3),  32'h22);
        chk("n3_sel1_valid", 32'(out_valid3), 32'd1);
        sel3 = 2'd3;
        @(negedge clk);
        chk("n3_oor_gnt", 32'(src_gnt3), 32'd0);
        @(posedge clk); #1;
        chk("n3_oor_data",  32'(out_data3),  32'd0);
        chk("n3_oor_valid", 32'(out_valid3), 32'd0);
        chk("n3_oor_src",   32'(out_src3),   32'd0);

        // Round robin over a non-power-of-two source count wraps 2 -> 0.
        mode3 = MODE_RR; src_req3 = 3'b111;
        for (int k = 0; k < 4; k++) begin
            e = k % N3;
            @(negedge clk);
            chk($sformatf("n3_rr%0d_gnt", k), 32'(src_gnt3), 32'd1 << e);
            @(posedge clk); #1;
            chk($sformatf("n3_rr%0d_src", k), 32'(out_src3), e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
